// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings for the data memory access unit
// Purpose: request size codes and FSM state encoding used by mem_access_unit
//          and mem_lane_align.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational byte/half lane extract and merge
// Purpose: extracts and sign/zero-extends the addressed lane of a memory word
//          for loads, and merges store data into the addressed lane for
//          read-modify-write stores.
// Ports:
//   i_size      request size (byte/half/word)
//   i_lane      byte address bits [1:0]
//   i_signed    1 = sign-extend loads
//   i_word      word read from memory
//   i_wdata     right-justified store data
//   o_load_data extended load result
//   o_merged    i_word with the addressed lane(s) replaced by i_wdata
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_signed,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [4:0]  w_shift;
    logic [31:0] w_mask;
    logic [31:0] w_shifted;

    // Big-endian places byte k at 8*(3-k); 3-k on two bits is simply ~k.
    always_comb begin
        w_shift = 5'd0;
        w_mask  = 32'hFFFF_FFFF;
        case (i_size)
            SIZE_BYTE: begin
                w_shift = BIG_ENDIAN ? {~i_lane, 3'b000} : {i_lane, 3'b000};
                w_mask  = 32'h0000_00FF << w_shift;
            end
            SIZE_HALF: begin
                w_shift = BIG_ENDIAN ? {~i_lane[1], 4'b0000} : {i_lane[1], 4'b0000};
                w_mask  = 32'h0000_FFFF << w_shift;
            end
            default: begin
                w_shift = 5'd0;
                w_mask  = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign w_shifted = i_word >> w_shift;

    always_comb begin
        o_load_data = i_word;
        case (i_size)
            SIZE_BYTE: o_load_data = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
            SIZE_HALF: o_load_data = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            default:   o_load_data = i_word;
        endcase
    end

    // Unaddressed bytes come straight from the word just read.
    assign o_merged = (i_word & ~w_mask) | ((i_wdata << w_shift) & w_mask);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store initiator for a word memory
// Purpose: accepts load/store requests from the MEM stage, checks alignment,
//          size and range, and runs word-only memory cycles (read-modify-write
//          for sub-word stores) with a ready/valid handshake.
// Ports:
//   i_clock, i_reset                 clock, async active-high reset
//   i_req_*/o_req_ready              request handshake and fields
//   o_resp_valid/err/rdata           one-cycle completion response
//   o_mem_address/writedata          word-aligned address and write word
//   o_mem_memread/memwrite           memory enables (decoded from state)
//   i_mem_readdata                   combinational memory read data
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS  = 256,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic        o_resp_err,
    output logic [31:0] o_resp_rdata,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_writedata,
    output logic        o_mem_memread,
    output logic        o_mem_memwrite,
    input  logic [31:0] i_mem_readdata
);

    localparam logic [31:0] LP_MEM_WORDS = 32'(MEM_WORDS);

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_signed;
    logic        r_write;
    logic [31:0] r_wdata;

    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_writedata;

    logic        w_accept;
    logic        w_req_err;
    logic        w_word_store;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign o_req_ready = (r_state == IDLE) && !i_reset;
    assign w_accept    = i_req_valid && o_req_ready;

    assign w_req_err = (i_req_size == SIZE_ILLEGAL)
                     || ((i_req_size == SIZE_HALF) && i_req_addr[0])
                     || ((i_req_size == SIZE_WORD) && (i_req_addr[1:0] != 2'b00))
                     || ({2'b00, i_req_addr[31:2]} >= LP_MEM_WORDS);

    // Full-word stores need no read; everything else that writes does RMW.
    assign w_word_store = i_req_write && (i_req_size == SIZE_WORD);

    mem_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_align (
        .i_size      (r_size),
        .i_lane      (r_lane),
        .i_signed    (r_signed),
        .i_word      (i_mem_readdata),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_state_next = RESP;
                    end else if (w_word_store) begin
                        w_state_next = WR;
                    end else begin
                        w_state_next = RD;
                    end
                end
            end
            RD:      w_state_next = r_write ? WR : RESP;
            WR:      w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_size          <= SIZE_BYTE;
            r_lane          <= 2'b00;
            r_signed        <= 1'b0;
            r_write         <= 1'b0;
            r_wdata         <= 32'd0;
            r_resp_valid    <= 1'b0;
            r_resp_err      <= 1'b0;
            r_resp_rdata    <= 32'd0;
            r_mem_address   <= 32'd0;
            r_mem_writedata <= 32'd0;
        end else begin
            r_resp_valid <= (w_state_next == RESP);
            if (w_accept) begin
                r_size       <= i_req_size;
                r_lane       <= i_req_addr[1:0];
                r_signed     <= i_req_signed;
                r_write      <= i_req_write;
                r_wdata      <= i_req_wdata;
                r_resp_err   <= w_req_err;
                r_resp_rdata <= 32'd0;
                if (!w_req_err) begin
                    r_mem_address <= {i_req_addr[31:2], 2'b00};
                    if (w_word_store) begin
                        r_mem_writedata <= i_req_wdata;
                    end
                end
            end
            // The read word is consumed on the same edge that ends RD.
            if (r_state == RD) begin
                if (r_write) begin
                    r_mem_writedata <= w_merged;
                end else begin
                    r_resp_rdata <= w_load_data;
                end
            end
        end
    end

    assign o_mem_memread   = (r_state == RD);
    assign o_mem_memwrite  = (r_state == WR);
    assign o_resp_valid    = r_resp_valid;
    assign o_resp_err      = r_resp_err;
    assign o_resp_rdata    = r_resp_rdata;
    assign o_mem_address   = r_mem_address;
    assign o_mem_writedata = r_mem_writedata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int MEM_WORDS = 256;

    logic        clock = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_write;
    logic [1:0]  i_req_size;
    logic        i_req_signed;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_resp_valid;
    logic        o_resp_err;
    logic [31:0] o_resp_rdata;
    logic [31:0] o_mem_address;
    logic [31:0] o_mem_writedata;
    logic        o_mem_memread;
    logic        o_mem_memwrite;
    logic [31:0] w_mem_readdata;

    logic [31:0] mem [0:MEM_WORDS-1];
    logic [7:0]  ref_b [0:MEM_WORDS*4-1];

    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [31:0] pl_data = 32'd0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rdata;

    always #5 clock = ~clock;

    mem_access_unit #(
        .MEM_WORDS  (MEM_WORDS),
        .BIG_ENDIAN (1'b0)
    ) dut (
        .i_clock         (clock),
        .i_reset         (i_reset),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_write     (i_req_write),
        .i_req_size      (i_req_size),
        .i_req_signed    (i_req_signed),
        .i_req_addr      (i_req_addr),
        .i_req_wdata     (i_req_wdata),
        .o_resp_valid    (o_resp_valid),
        .o_resp_err      (o_resp_err),
        .o_resp_rdata    (o_resp_rdata),
        .o_mem_address   (o_mem_address),
        .o_mem_writedata (o_mem_writedata),
        .o_mem_memread   (o_mem_memread),
        .o_mem_memwrite  (o_mem_memwrite),
        .i_mem_readdata  (w_mem_readdata)
    );

    // Attached word memory: combinational read, falling-edge write.
    assign w_mem_readdata = mem[o_mem_address[9:2]];

    always @(negedge clock) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (o_mem_memwrite) begin
            mem[o_mem_address[9:2]] <= o_mem_writedata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: little-endian byte array.
    function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b01 && a[0]) return 1'b1;
        if (sz == 2'b10 && (a % 4) != 0) return 1'b1;
        if ((a / 4) >= MEM_WORDS) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int          n = 1 << sz;
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_b[int'(a) + i]) << (8 * i));
        if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) ref_b[int'(a) + i] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    function automatic logic [31:0] model_word(input int idx);
        return {ref_b[idx * 4 + 3], ref_b[idx * 4 + 2], ref_b[idx * 4 + 1], ref_b[idx * 4]};
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_idx  = 8'(idx);
        pl_data = d;
        for (int i = 0; i < 4; i++) ref_b[idx * 4 + i] = 8'((d >> (8 * i)) & 32'hFF);
        @(negedge clock);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd);
        bit          exp_err;
        logic [31:0] exp_rd;
        int          exp_lat, exp_nrd, exp_nwr;
        int          lat, nrd, nwr, nrdy, rd_first, wr_first, waited;
        bit          seen;
        logic [31:0] addr_seen;

        exp_err = model_err(ad, sz);
        exp_rd  = 32'd0;
        if (exp_err) begin
            exp_lat = 1; exp_nrd = 0; exp_nwr = 0;
        end else if (!wr) begin
            exp_lat = 2; exp_nrd = 1; exp_nwr = 0;
            exp_rd  = model_load(ad, sz, sg);
        end else if (sz == 2'b10) begin
            exp_lat = 2; exp_nrd = 0; exp_nwr = 1;
        end else begin
            exp_lat = 3; exp_nrd = 1; exp_nwr = 1;
        end

        waited = 0;
        while (!o_req_ready && waited < 20) begin
            @(posedge clock);
            #1;
            waited++;
        end
        check("ready_before_req", 32'(o_req_ready), 32'd1);

        i_req_valid  = 1'b1;
        i_req_write  = wr;
        i_req_size   = sz;
        i_req_signed = sg;
        i_req_addr   = ad;
        i_req_wdata  = wd;
        @(posedge clock);
        #1;
        // Junk on the request bus while busy must be ignored.
        i_req_valid  = 1'($urandom_range(0, 1));
        i_req_write  = 1'($urandom_range(0, 1));
        i_req_size   = 2'($urandom_range(0, 3));
        i_req_addr   = $urandom;
        i_req_wdata  = $urandom;

        lat = 1; nrd = 0; nwr = 0; nrdy = 0; seen = 0;
        rd_first = -1; wr_first = -1; addr_seen = 32'hFFFF_FFFF;
        while (1) begin
            if (o_mem_memread) begin
                nrd++;
                if (rd_first < 0) rd_first = lat;
                addr_seen = o_mem_address;
            end
            if (o_mem_memwrite) begin
                nwr++;
                if (wr_first < 0) wr_first = lat;
                addr_seen = o_mem_address;
            end
            if (o_req_ready) nrdy++;
            if (o_resp_valid) begin
                seen = 1;
                break;
            end
            if (lat >= 10) break;
            @(posedge clock);
            #1;
            lat++;
        end
        i_req_valid = 1'b0;

        check("resp_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_err", 32'(o_resp_err), 32'(exp_err));
        check("resp_rdata", o_resp_rdata, exp_rd);
        check("memread_cycles", 32'(nrd), 32'(exp_nrd));
        check("memwrite_cycles", 32'(nwr), 32'(exp_nwr));
        check("ready_low_busy", 32'(nrdy), 32'd0);
        if (!exp_err) check("mem_address", addr_seen, {ad[31:2], 2'b00});
        if (exp_nrd == 1 && exp_nwr == 1) check("read_before_write", 32'(rd_first < wr_first), 32'd1);
        last_rdata = o_resp_rdata;

        @(posedge clock);
        #1;
        check("resp_one_cycle", 32'(o_resp_valid), 32'd0);
        check("ready_after_resp", 32'(o_req_ready), 32'd1);

        if (!exp_err && wr) model_store(ad, sz, wd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nrv;
        logic [1:0]  sz;
        logic [31:0] ad;

        i_reset      = 1'b1;
        i_req_valid  = 1'b0;
        i_req_write  = 1'b0;
        i_req_size   = 2'b00;
        i_req_signed = 1'b0;
        i_req_addr   = 32'd0;
        i_req_wdata  = 32'd0;
        last_rdata   = 32'd0;

        for (int i = 0; i < MEM_WORDS; i++) preload(i, $urandom);

        check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
        check("rst_resp_err", 32'(o_resp_err), 32'd0);
        check("rst_resp_rdata", o_resp_rdata, 32'd0);
        check("rst_mem_address", o_mem_address, 32'd0);
        check("rst_mem_writedata", o_mem_writedata, 32'd0);
        check("rst_memread", 32'(o_mem_memread), 32'd0);
        check("rst_memwrite", 32'(o_mem_memwrite), 32'd0);
        i_reset = 1'b0;
        @(posedge clock);
        #1;
        check("ready_after_reset", 32'(o_req_ready), 32'd1);

        // Word store then word load.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check("word_mem_after_store", mem[4], 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        check("word_load_value", last_rdata, 32'hDEAD_BEEF);

        // Sub-word store read-modify-write.
        preload(8, 32'h1122_3344);
        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AA);
        check("byte_store_merge", mem[8], 32'h1122_AA44);

        // Load extension.
        preload(12, 32'h80FF_7F01);
        do_req(1'b0, 2'b00, 1'b1, 32'h32, 32'd0);
        check("lb_signed", last_rdata, 32'hFFFF_FFFF);
        do_req(1'b0, 2'b00, 1'b0, 32'h33, 32'd0);
        check("lbu", last_rdata, 32'h0000_0080);
        do_req(1'b0, 2'b01, 1'b1, 32'h30, 32'd0);
        check("lh_signed", last_rdata, 32'h0000_7F01);

        // Errors: misaligned, out of range, illegal size.
        do_req(1'b0, 2'b01, 1'b0, 32'h41, 32'd0);
        do_req(1'b1, 2'b10, 1'b0, 32'h42, 32'h1234_5678);
        do_req(1'b0, 2'b10, 1'b0, 32'(MEM_WORDS * 4), 32'd0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'd0);

        // Reset during WR before the falling edge.
        preload(20, 32'h1234_5678);
        i_req_valid = 1'b1;
        i_req_write = 1'b1;
        i_req_size  = 2'b10;
        i_req_addr  = 32'h50;
        i_req_wdata = 32'hCAFE_F00D;
        @(posedge clock);
        #1;
        i_req_valid = 1'b0;
        check("rst_wr_active", 32'(o_mem_memwrite), 32'd1);
        i_reset = 1'b1;
        #1;
        check("rst_wr_memwrite_drop", 32'(o_mem_memwrite), 32'd0);
        @(negedge clock);
        #1;
        i_reset = 1'b0;
        nrv = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_resp_valid) nrv++;
            @(posedge clock);
            #1;
        end
        check("rst_wr_no_resp", 32'(nrv), 32'd0);
        check("rst_wr_ready", 32'(o_req_ready), 32'd1);
        check("rst_wr_mem_unchanged", mem[20], 32'h1234_5678);

        // Randomized requests against the byte-array model.
        for (int k = 0; k < 200; k++) begin
            sz = 2'($urandom_range(0, 3));
            ad = 32'($urandom_range(0, MEM_WORDS * 4 + 31));
            if ($urandom_range(0, 15) == 0) ad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) ad[0] = 1'b0;
                if (sz == 2'b10) ad[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
        end

        for (int i = 0; i < MEM_WORDS; i++) check("final_mem", mem[i], model_word(i));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
